// File: rtl/multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer
//
// Purpose:
//   Adds two W-bit operands plus a carry-in, where W = SLICEBITS*NUMSLICES.
//   It reuses a single SLICEBITS-wide carry-lookahead adder over several
//   cycles. One slice is processed per cycle, least-significant slice first.
//   The carry between slices is held in a register, so the chained result is
//   the same as one W-bit adder. Operands come in and results go out through
//   a valid/ready handshake.
//
// Optional feature (macro ADDSEQ_OVERFLOW_EN):
//   When defined, an extra output `ovf` reports the signed overflow of the
//   W-bit add. It is registered on the final ADD edge and is valid with
//   out_valid. When the macro is undefined, the port and its logic are absent.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   a, b, c_in are valid
//   in_ready   out  1   block can accept operands (state IDLE)
//   a          in   W   operand A
//   b          in   W   operand B
//   c_in       in   1   carry into bit 0
//   out_valid  out  1   s and c_out are valid (state DONE)
//   out_ready  in   1   consumer accepts the result
//   s          out  W   registered sum
//   c_out      out  1   registered carry out of bit W-1
//   busy       out  1   high in ADD and DONE
//   ovf        out  1   signed overflow (only with ADDSEQ_OVERFLOW_EN)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// nBitCarryLookAheadAdder
//
// Purpose:
//   Combinational NUMBITS-wide carry-lookahead adder. Each carry is built
//   directly as a sum of products of the generate/propagate terms. Carries
//   are not rippled from the previous bit.
//
// Ports:
//   a, b    in   NUMBITS   addends
//   c_in    in   1         carry into bit 0
//   s       out  NUMBITS   sum
//   c_out   out  1         carry out of bit NUMBITS-1
// ---------------------------------------------------------------------------
module nBitCarryLookAheadAdder #(
    parameter int NUMBITS = 4
) (
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               c_in,
    output logic [NUMBITS-1:0] s,
    output logic               c_out
);

    logic [NUMBITS-1:0] gen;
    logic [NUMBITS-1:0] prop;
    logic [NUMBITS:0]   carry;
    logic               acc;
    logic               pchain;

    // carry[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c_in
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        acc      = 1'b0;
        pchain   = 1'b1;
        carry[0] = c_in;
        for (int i = 0; i < NUMBITS; i++) begin
            acc    = 1'b0;
            pchain = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc    = acc | (pchain & gen[j]);
                pchain = pchain & prop[j];
            end
            carry[i+1] = acc | (pchain & c_in);
        end
    end

    assign s     = prop ^ carry[NUMBITS-1:0];
    assign c_out = carry[NUMBITS];

endmodule

module multiword_add_sequencer #(
    parameter int SLICEBITS = 4,
    parameter int NUMSLICES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SLICEBITS*NUMSLICES-1:0] a,
    input  logic [SLICEBITS*NUMSLICES-1:0] b,
    input  logic                           c_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SLICEBITS*NUMSLICES-1:0] s,
    output logic                           c_out,
    output logic                           busy
`ifdef ADDSEQ_OVERFLOW_EN
    ,
    output logic                           ovf
`endif
);

    localparam int W    = SLICEBITS * NUMSLICES;
    localparam int IDXW = (NUMSLICES > 1) ? $clog2(NUMSLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control and result registers
    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q,   idx_d;
    logic                carry_q, carry_d;
    logic [W-1:0]        s_q,     s_d;
    logic                cout_q,  cout_d;
`ifdef ADDSEQ_OVERFLOW_EN
    logic                ovf_q,   ovf_d;
`endif

    // Operand registers. The live ports are ignored once an operation has
    // been accepted.
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;

    // Slice datapath around the single shared adder
    logic [SLICEBITS-1:0] a_sl;
    logic [SLICEBITS-1:0] b_sl;
    logic [SLICEBITS-1:0] add_s;
    logic                 add_co;
    logic                 last_slice;
    logic                 msb_cin;

    // Select the operand slice addressed by the slice index. A compare-based
    // mux keeps the index arithmetic out of the part-select.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NUMSLICES; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_sl = a_q[k*SLICEBITS +: SLICEBITS];
                b_sl = b_q[k*SLICEBITS +: SLICEBITS];
            end
        end
    end

    nBitCarryLookAheadAdder #(
        .NUMBITS (SLICEBITS)
    ) u_cla (
        .a     (a_sl),
        .b     (b_sl),
        .c_in  (carry_q),
        .s     (add_s),
        .c_out (add_co)
    );

    assign last_slice = (idx_q == IDXW'(NUMSLICES - 1));

    // On the top slice, the carry into bit W-1 can be recovered from that
    // bit's sum: c = a ^ b ^ s.
    assign msb_cin = a_sl[SLICEBITS-1] ^ b_sl[SLICEBITS-1] ^ add_s[SLICEBITS-1];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef ADDSEQ_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end

            ADD: begin
                for (int k = 0; k < NUMSLICES; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        s_d[k*SLICEBITS +: SLICEBITS] = add_s;
                    end
                end
                carry_d = add_co;
                if (last_slice) begin
                    cout_d  = add_co;
`ifdef ADDSEQ_OVERFLOW_EN
                    ovf_d   = msb_cin ^ add_co;
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                end
            end

            DONE: begin
                // s and c_out stay unchanged until the consumer takes them.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State and result registers. A reset abandons any operation in flight
    // and clears the visible result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
`ifdef ADDSEQ_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
`ifdef ADDSEQ_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand registers carry data only and have no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    // Handshake outputs are decoded purely from the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign c_out     = cout_q;
`ifdef ADDSEQ_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

    localparam int SB = 4;
    localparam int NS = 4;
    localparam int W  = SB * NS;
    localparam int XW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
    logic [W-1:0]  a, b, s;
    logic          x_in_valid, x_in_ready, x_c_in, x_out_valid, x_out_ready, x_c_out, x_busy;
    logic [XW-1:0] x_a, x_b, x_s;
`ifdef ADDSEQ_OVERFLOW_EN
    logic          ovf, x_ovf;
`endif

    multiword_add_sequencer #(.SLICEBITS(SB), .NUMSLICES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .c_out(c_out), .busy(busy)
`ifdef ADDSEQ_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    multiword_add_sequencer #(.SLICEBITS(2), .NUMSLICES(2)) dut_x (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .c_in(x_c_in), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .s(x_s), .c_out(x_c_out), .busy(x_busy)
`ifdef ADDSEQ_OVERFLOW_EN
        , .ovf(x_ovf)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[11];

    // Wait (bounded) until the main DUT is idle, at a negedge.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
        check(name, 32'(in_ready), 32'd1);
    endtask

    // Present operands for one edge, then scramble the ports and count
    // cycles until out_valid. Also count ADD cycles with bad in_ready/busy.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         output int lat, output int ctl_bad);
        a = av; b = bv; c_in = ci; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = ~ci;
        lat = 0; ctl_bad = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ctl_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic retire(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_ret"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int lat, bad, stuck;
        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[5]  = '{16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0};
        vecs[6]  = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
        vecs[9]  = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
        x_in_valid = 1'b0; x_out_ready = 1'b0; x_a = '0; x_b = '0; x_c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s", 32'(s), 32'd0);
        check("rst_ctl", {27'd0, c_out, out_valid, busy, in_ready, 1'b0}, 32'b00010);
`ifdef ADDSEQ_OVERFLOW_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            wait_idle($sformatf("v%0d_idle", i));
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bad);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_addctl", i), 32'(bad), 32'd0);
            check($sformatf("v%0d_donectl", i), {30'd0, busy, in_ready}, 32'b10);
            check($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].s));
            check($sformatf("v%0d_cout", i), 32'(c_out), 32'(vecs[i].co));
`ifdef ADDSEQ_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
`endif
            retire($sformatf("v%0d", i));
        end

        // Backpressure with an ignored in_valid pulse during DONE
        wait_idle("bp_idle");
        issue(16'h8000, 16'h8000, 1'b0, lat, bad);
        check("bp_lat", 32'(lat), 32'd4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d", k), {15'd0, out_valid, c_out, s}, {15'd0, 1'b1, 1'b1, 16'h0000});
            if (k == 1) begin
                a = 16'hAAAA; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        retire("bp");
        stuck = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stuck++;
            @(negedge clk);
        end
        check("bp_no_second", 32'(stuck), 32'd0);

        // Reset in the middle of an operation
        wait_idle("rm_idle");
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rm_ctl", {28'd0, out_valid, c_out, busy, in_ready}, 32'b0001);
        check("rm_s", 32'(s), 32'd0);
        stuck = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid !== 1'b0) stuck++;
            @(negedge clk);
        end
        check("rm_no_result", 32'(stuck), 32'd0);
        issue(16'h0002, 16'h0003, 1'b0, lat, bad);
        check("rm_next_lat", 32'(lat), 32'd4);
        check("rm_next_s", {15'd0, c_out, s}, 32'h0005);
        retire("rm_next");

        // Exhaustive on the 2x2-bit instance
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    logic [4:0] sum;
                    logic       xov;
                    sum = 5'(av) + 5'(bv) + 5'(ci);
                    xov = (av[3] == bv[3]) && (sum[3] != av[3]);
                    for (int t = 0; t < 10 && x_in_ready !== 1'b1; t++) @(negedge clk);
                    x_a = 4'(av); x_b = 4'(bv); x_c_in = ci[0]; x_in_valid = 1'b1;
                    @(negedge clk);
                    x_in_valid = 1'b0;
                    for (int t = 0; t < 10 && x_out_valid !== 1'b1; t++) @(negedge clk);
`ifdef ADDSEQ_OVERFLOW_EN
                    check($sformatf("x_%0d_%0d_%0d", av, bv, ci),
                          {25'd0, x_out_valid, x_busy, x_ovf, x_c_out, x_s},
                          {25'd0, 1'b1, 1'b1, xov, sum});
`else
                    check($sformatf("x_%0d_%0d_%0d", av, bv, ci),
                          {25'd0, x_out_valid, x_busy, xov & 1'b0, x_c_out, x_s},
                          {25'd0, 1'b1, 1'b1, 1'b0, sum});
`endif
                    x_out_ready = 1'b1;
                    @(negedge clk);
                    x_out_ready = 1'b0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
